a64_inst_encoder: RTL and testbench
===================================

Name: a64_inst_encoder

Overview:
- Encodes A64 instructions: the inverse of the ALU-control/immediate decode path.
- Takes symbolic commands (op, registers, 64-bit immediate) over a valid/ready interface and streams 32-bit instruction words out over a second valid/ready interface.
- Drives instruction-memory preload, the boot stub and the decode testbenches.
- Immediate materialisation expands into a MOVZ/MOVK sequence, so one command can produce 1-4 words.

Parameters:
- SHIFTED_SUBI, 1: when 1, SUBI immediates of the form imm12<<12 are encoded with sh=1; when 0 they are errors.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when valid&ready
- cmd_op  in  2  0=MOVI, 1=SUBI, 2=CMP, 3=CBZ
- cmd_rd  in  5  Rd/Rt
- cmd_rn  in  5  Rn
- cmd_rm  in  5  Rm
- cmd_imm  in  64  immediate; byte offset for CBZ, signed
- inst_valid  out  1  instruction word valid
- inst_ready  in  1  downstream accepts word
- inst_data  out  32  encoded word
- inst_last  out  1  final word of current command
- cmd_err  out  1  one-cycle pulse, command rejected

Behaviour:
- Reset (async, rst_n=0): state IDLE, inst_valid=0, inst_data=0, inst_last=0, cmd_err=0, cmd_ready=0 while in reset; cmd_ready=1 from the first clock after release.
- States:
  - IDLE: cmd_ready=1, inst_valid=0.
  - EMIT: output register holds a word; inst_valid=1.
- Latency: command accepted at edge N gives inst_valid=1 with the first word from cycle N+1.
- Output rules:
  - inst_data and inst_last stay stable while inst_valid & !inst_ready.
  - Consecutive words of one command are back-to-back: the next word loads on the handshake edge, with no bubble.
- cmd_ready=1 in IDLE, and in EMIT when inst_last & inst_ready (pass-through: a new command is accepted on the same edge the last word retires). Otherwise 0.
- Encodings (sf=1, 64-bit):
  - MOVZ = 0xD2800000 | hw<<21 | imm16<<5 | Rd
  - MOVK = 0xF2800000 | hw<<21 | imm16<<5 | Rd
  - SUBI = 0xD1000000 | sh<<22 | imm12<<10 | Rn<<5 | Rd
  - CMP (SUBS shifted reg, LSL #0, Rd=31) = 0xEB00001F | Rm<<16 | Rn<<5
  - CBZ = 0xB4000000 | imm19<<5 | Rt
- MOVI:
  - Halfwords h0..h3 of imm, hw = halfword index.
  - First word is MOVZ for the lowest non-zero halfword, then MOVK for each higher non-zero halfword, ascending.
  - imm=0 emits a single MOVZ hw=0, imm16=0.
  - Word count 1-4; inst_last on the final word.
- SUBI:
  - imm[63:12]==0: sh=0.
  - Else, if SHIFTED_SUBI=1, imm[11:0]==0 and imm[63:24]==0: sh=1, imm12=imm[23:12].
  - Else error.
- CBZ:
  - Requires imm[1:0]==0 and imm[63:20] all equal to imm[20] (range −1 MiB..+1 MiB−4).
  - imm19 = imm[20:2]. Otherwise error.
- CMP: always a single word; imm ignored.
- Error: the command is consumed, cmd_err=1 for the cycle after acceptance, no word emitted, state stays IDLE.
- Reset mid-sequence: remaining words are discarded; the partial command is not replayed.
- cmd_* inputs are sampled only at acceptance; later changes have no effect.

Optional Feature:
- Macro A64_ENC_STATS_EN.
- Defined: adds output ports enc_word_cnt[31:0] (increments on each inst handshake) and enc_err_cnt[15:0] (increments on each cmd_err pulse, saturating at 0xFFFF). Both reset to 0 asynchronously. enc_word_cnt wraps at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- MOVI rd=3 imm=0 -> one word 0xD2800003, inst_last=1, valid at N+1.
- MOVI rd=1 imm=0x000012340000ABCD -> 0xD29579A1 (last=0), then 0xF2C24681 (last=1), back-to-back with inst_ready=1.
- SUBI rd=2 rn=2 imm=1 -> 0xD1000442; SUBI rd=0 rn=0 imm=0x5000 -> 0xD1401400; SUBI imm=0x1001 -> cmd_err pulse, no word.
- CMP rn=1 rm=2 -> 0xEB02003F; CBZ rt=0 imm=-8 -> 0xB4FFFFC0; CBZ imm=6 -> cmd_err, no inst_valid.
- MOVI rd=0 imm=0xFFFFFFFFFFFFFFFF with inst_ready low 3 cycles on each word:
  - -> words 0xD29FFFE0, 0xF2BFFFE0, 0xF2DFFFE0, 0xF2FFFFE0 in order, held stable while stalled.
  - -> cmd_ready=0 until the last handshake; a next command queued then is accepted on that edge.
- Assert rst_n=0 after the second word of a 4-word MOVI -> inst_valid=0 immediately, no further words; a new CMP after release encodes correctly.

Source files
------------

// File: rtl/a64_inst_encoder.sv
// a64_inst_encoder: turns symbolic A64 commands into 32-bit instruction words.
//
// One command (MOVI, SUBI, CMP, CBZ) is accepted over a valid/ready handshake.
// It yields one to four words on a second valid/ready stream; only MOVI produces
// more than one word (a MOVZ/MOVK sequence). Commands that cannot be encoded are
// consumed and flagged with a one-cycle cmd_err pulse. No word is emitted for them.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_op                0=MOVI 1=SUBI 2=CMP 3=CBZ
//   cmd_rd/rn/rm          register fields (cmd_rd is Rt for CBZ)
//   cmd_imm               64-bit immediate (signed byte offset for CBZ)
//   inst_valid/ready      instruction word handshake
//   inst_data, inst_last  encoded word, final word of the current command
//   cmd_err               one-cycle pulse after a rejected command is accepted
//   enc_word_cnt          (A64_ENC_STATS_EN) words handed off, wraps at 2^32
//   enc_err_cnt           (A64_ENC_STATS_EN) cmd_err pulses, saturates at 0xFFFF
//
// Optional feature macro: A64_ENC_STATS_EN adds the two statistics counters.

module a64_inst_encoder #(
    parameter bit SHIFTED_SUBI = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_rd,
    input  logic [4:0]  cmd_rn,
    input  logic [4:0]  cmd_rm,
    input  logic [63:0] cmd_imm,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic        inst_last,
`ifdef A64_ENC_STATS_EN
    output logic [31:0] enc_word_cnt,
    output logic [15:0] enc_err_cnt,
`endif
    output logic        cmd_err
);

    localparam logic [1:0] OpMovi = 2'd0;
    localparam logic [1:0] OpSubi = 2'd1;
    localparam logic [1:0] OpCmp  = 2'd2;
    localparam logic [1:0] OpCbz  = 2'd3;

    typedef enum logic {StIdle, StEmit} state_e;

    state_e      state_q, state_d;
    logic        ready_en_q;       // holds cmd_ready low until the first clock after reset
    logic [31:0] data_q, data_d;
    logic        last_q, last_d;
    logic [3:0]  rem_q, rem_d;     // non-zero halfwords still owed as MOVK words
    logic [63:0] imm_q, imm_d;
    logic [4:0]  rd_q, rd_d;
    logic        err_q, err_d;

    // Index of the lowest set bit; 0 for an empty mask.
    function automatic logic [1:0] lowest_hw(input logic [3:0] mask);
        lowest_hw = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) lowest_hw = 2'(i);
        end
    endfunction

    function automatic logic [31:0] mov_word(input logic keep, input logic [1:0] hw,
                                             input logic [15:0] imm16, input logic [4:0] rd);
        mov_word = (keep ? 32'hF280_0000 : 32'hD280_0000) | {9'b0, hw, 21'b0}
                 | {11'b0, imm16, 5'b0} | {27'b0, rd};
    endfunction

    // Decode of the command currently on the cmd_* inputs.
    logic [3:0]  nz;
    logic [1:0]  ld_hw;
    logic [31:0] ld_word;
    logic        ld_last;
    logic [3:0]  ld_rem;
    logic        ld_err;

    always_comb begin
        nz      = '0;
        ld_hw   = 2'd0;
        ld_word = '0;
        ld_last = 1'b1;
        ld_rem  = '0;
        ld_err  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nz[i] = |cmd_imm[16*i +: 16];
        end
        unique case (cmd_op)
            OpMovi: begin
                // All-zero immediate falls out as MOVZ hw=0 imm16=0.
                ld_hw   = lowest_hw(nz);
                ld_word = mov_word(1'b0, ld_hw, cmd_imm[{ld_hw, 4'b0} +: 16], cmd_rd);
                ld_rem  = nz & ~(4'b1 << ld_hw);
                ld_last = (ld_rem == 4'b0);
            end
            OpSubi: begin
                if (cmd_imm[63:12] == '0) begin
                    ld_word = 32'hD100_0000 | {10'b0, cmd_imm[11:0], 10'b0}
                            | {22'b0, cmd_rn, 5'b0} | {27'b0, cmd_rd};
                end else if (SHIFTED_SUBI && cmd_imm[11:0] == '0 && cmd_imm[63:24] == '0) begin
                    ld_word = 32'hD140_0000 | {10'b0, cmd_imm[23:12], 10'b0}
                            | {22'b0, cmd_rn, 5'b0} | {27'b0, cmd_rd};
                end else begin
                    ld_err = 1'b1;
                end
            end
            OpCmp: begin
                ld_word = 32'hEB00_001F | {11'b0, cmd_rm, 16'b0} | {22'b0, cmd_rn, 5'b0};
            end
            OpCbz: begin
                // Word aligned and sign-extended from bit 20: +/-1 MiB reach.
                if (cmd_imm[1:0] == 2'b0 && cmd_imm[63:20] == {44{cmd_imm[20]}}) begin
                    ld_word = 32'hB400_0000 | {8'b0, cmd_imm[20:2], 5'b0} | {27'b0, cmd_rd};
                end else begin
                    ld_err = 1'b1;
                end
            end
            default: ld_err = 1'b1;
        endcase
    end

    // Next MOVK of an in-flight MOVI sequence.
    logic [1:0]  nxt_hw;
    logic [31:0] nxt_word;
    logic [3:0]  nxt_rem;

    always_comb begin
        nxt_hw   = lowest_hw(rem_q);
        nxt_word = mov_word(1'b1, nxt_hw, imm_q[{nxt_hw, 4'b0} +: 16], rd_q);
        nxt_rem  = rem_q & ~(4'b1 << nxt_hw);
    end

    logic accept;
    logic handshake;

    always_comb begin
        inst_valid = (state_q == StEmit);
        inst_data  = data_q;
        inst_last  = last_q;
        cmd_err    = err_q;
        // A new command may overlap the edge on which the final word retires.
        cmd_ready  = ready_en_q &
                     ((state_q == StIdle) || (last_q && inst_ready));
        accept     = cmd_valid && cmd_ready;
        handshake  = inst_valid && inst_ready;

        state_d = state_q;
        data_d  = data_q;
        last_d  = last_q;
        rem_d   = rem_q;
        imm_d   = imm_q;
        rd_d    = rd_q;
        err_d   = 1'b0;

        if (handshake && !last_q) begin
            data_d = nxt_word;
            rem_d  = nxt_rem;
            last_d = (nxt_rem == 4'b0);
        end else if (handshake) begin
            state_d = StIdle;
        end

        if (accept) begin
            imm_d = cmd_imm;
            rd_d  = cmd_rd;
            if (ld_err) begin
                err_d   = 1'b1;
                state_d = StIdle;
            end else begin
                state_d = StEmit;
                data_d  = ld_word;
                last_d  = ld_last;
                rem_d   = ld_rem;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ready_en_q <= 1'b0;
            data_q     <= '0;
            last_q     <= 1'b0;
            rem_q      <= '0;
            imm_q      <= '0;
            rd_q       <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
            data_q     <= data_d;
            last_q     <= last_d;
            rem_q      <= rem_d;
            imm_q      <= imm_d;
            rd_q       <= rd_d;
            err_q      <= err_d;
        end
    end

`ifdef A64_ENC_STATS_EN
    logic [31:0] word_cnt_q;
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (handshake) word_cnt_q <= word_cnt_q + 32'd1;
            if (err_q && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign enc_word_cnt = word_cnt_q;
    assign enc_err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_a64_inst_encoder.sv
// Self-checking bench for a64_inst_encoder: directed test-plan vectors, a stalled
// four-word MOVI, command pass-through, reset in mid-sequence and randomized
// commands checked against an arithmetic reference model.

module tb_a64_inst_encoder;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_rd;
    logic [4:0]  cmd_rn;
    logic [4:0]  cmd_rm;
    logic [63:0] cmd_imm;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic        inst_last;
    logic        cmd_err;
`ifdef A64_ENC_STATS_EN
    logic [31:0] enc_word_cnt;
    logic [15:0] enc_err_cnt;
`endif

    a64_inst_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_rd     (cmd_rd),
        .cmd_rn     (cmd_rn),
        .cmd_rm     (cmd_rm),
        .cmd_imm    (cmd_imm),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_data  (inst_data),
        .inst_last  (inst_last),
`ifdef A64_ENC_STATS_EN
        .enc_word_cnt (enc_word_cnt),
        .enc_err_cnt  (enc_err_cnt),
`endif
        .cmd_err    (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_compared = 0;
    int n_mismatched = 0;

    // Results of the most recent run_cmd.
    logic [31:0] got_words[$];
    logic        got_last[$];
    int          hs_cyc[$];
    int          err_cycles;
    int          first_delay;
    bit          stable_ok;
    bit          ready_ok;
    bit          timed_out;

    // Reference model output.
    logic [31:0] exp_words[$];
    bit          exp_err;

    typedef struct packed {
        logic [1:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [63:0] imm;
        logic [2:0]  n;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    // Encodings computed from the instruction formats with plain arithmetic.
    task automatic model_cmd(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rn,
                             input logic [4:0] rm, input logic [63:0] imm);
        longint unsigned u;
        longint          s;
        longint unsigned h;
        longint unsigned w;
        bit              first;
        exp_words.delete();
        exp_err = 1'b0;
        u = imm;
        s = imm;
        case (op)
            2'd0: begin
                first = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    h = (u >> (16 * k)) & 64'hFFFF;
                    if (h != 0) begin
                        w = (first ? 64'hD280_0000 : 64'hF280_0000) + longint'(k) * 2097152
                          + h * 32 + longint'(rd);
                        exp_words.push_back(w[31:0]);
                        first = 1'b0;
                    end
                end
                if (first) begin
                    w = 64'hD280_0000 + longint'(rd);
                    exp_words.push_back(w[31:0]);
                end
            end
            2'd1: begin
                if (u < 4096) begin
                    w = 64'hD100_0000 + u * 1024 + longint'(rn) * 32 + longint'(rd);
                    exp_words.push_back(w[31:0]);
                end else if (u % 4096 == 0 && u < 16777216) begin
                    w = 64'hD100_0000 + 4194304 + (u / 4096) * 1024 + longint'(rn) * 32
                      + longint'(rd);
                    exp_words.push_back(w[31:0]);
                end else begin
                    exp_err = 1'b1;
                end
            end
            2'd2: begin
                w = 64'hEB00_001F + longint'(rm) * 65536 + longint'(rn) * 32;
                exp_words.push_back(w[31:0]);
            end
            default: begin
                if (s % 4 == 0 && s >= -1048576 && s <= 1048572) begin
                    w = 64'hB400_0000 + ((s / 4) & 64'h7FFFF) * 32 + longint'(rd);
                    exp_words.push_back(w[31:0]);
                end else begin
                    exp_err = 1'b1;
                end
            end
        endcase
    endtask

    // Presents one command, then collects its words with `stall` low-ready
    // cycles before each handshake. Fills the got_* results above.
    task automatic run_cmd(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rn,
                           input logic [4:0] rm, input logic [63:0] imm, input int stall);
        int          guard;
        int          cyc;
        int          wait_left;
        bit          done;
        bit          have_prev;
        logic [31:0] prev_data;
        logic        prev_last;
        got_words.delete();
        got_last.delete();
        hs_cyc.delete();
        err_cycles  = 0;
        first_delay = -1;
        stable_ok   = 1'b1;
        ready_ok    = 1'b1;
        timed_out   = 1'b0;
        prev_data   = '0;
        prev_last   = 1'b0;
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_rd     = rd;
        cmd_rn     = rn;
        cmd_rm     = rm;
        cmd_imm    = imm;
        inst_ready = 1'b0;
        #1;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!cmd_ready) timed_out = 1'b1;
        @(negedge clk);
        // Scramble the command bus: the encoder must have sampled it already.
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_rd    = 5'($urandom);
        cmd_rn    = 5'($urandom);
        cmd_rm    = 5'($urandom);
        cmd_imm   = {$urandom, $urandom};
        cyc       = 1;
        wait_left = stall;
        done      = 1'b0;
        have_prev = 1'b0;
        while (!done && cyc < 200) begin
            #1;
            if (cmd_err) err_cycles++;
            if (inst_valid) begin
                if (first_delay < 0) first_delay = cyc;
                if (have_prev && (inst_data !== prev_data || inst_last !== prev_last))
                    stable_ok = 1'b0;
                prev_data  = inst_data;
                prev_last  = inst_last;
                have_prev  = 1'b1;
                inst_ready = (wait_left == 0);
                #1;
                if (cmd_ready !== (inst_last & inst_ready)) ready_ok = 1'b0;
                if (inst_ready) begin
                    got_words.push_back(inst_data);
                    got_last.push_back(inst_last);
                    hs_cyc.push_back(cyc);
                    have_prev = 1'b0;
                    wait_left = stall;
                    if (inst_last) done = 1'b1;
                end else begin
                    wait_left--;
                end
            end else begin
                inst_ready = 1'b0;
                if (cyc >= 2) done = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        if (!done) timed_out = 1'b1;
        inst_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = '0;
        cmd_rd     = '0;
        cmd_rn     = '0;
        cmd_rm     = '0;
        cmd_imm    = '0;
        inst_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_compared++;
        if (inst_valid !== 1'b0) begin
            n_mismatched++;
            $display("FAIL reset_inst_valid: got %b expected 0", inst_valid);
        end
        n_compared++;
        if (inst_data !== 32'h0 || inst_last !== 1'b0) begin
            n_mismatched++;
            $display("FAIL reset_inst_data: got %h/%b expected 00000000/0", inst_data, inst_last);
        end
        n_compared++;
        if (cmd_err !== 1'b0 || cmd_ready !== 1'b0) begin
            n_mismatched++;
            $display("FAIL reset_cmd: got err=%b ready=%b expected 0/0", cmd_err, cmd_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_compared++;
        if (cmd_ready !== 1'b1) begin
            n_mismatched++;
            $display("FAIL ready_after_release: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_directed;
        vec_t vecs[$];
        vec_t v;
        vecs.push_back('{2'd0, 5'd3, 5'd0, 5'd0, 64'h0, 3'd1, 32'hD280_0003, 32'h0});
        vecs.push_back('{2'd0, 5'd1, 5'd0, 5'd0, 64'h0000_1234_0000_ABCD, 3'd2,
                         32'hD295_79A1, 32'hF2C2_4681});
        vecs.push_back('{2'd0, 5'd5, 5'd0, 5'd0, 64'h8000_0000_0000_0000, 3'd1,
                         32'hD2F0_0005, 32'h0});
        vecs.push_back('{2'd1, 5'd2, 5'd2, 5'd0, 64'h1, 3'd1, 32'hD100_0442, 32'h0});
        vecs.push_back('{2'd1, 5'd0, 5'd0, 5'd0, 64'h5000, 3'd1, 32'hD140_1400, 32'h0});
        vecs.push_back('{2'd1, 5'd1, 5'd1, 5'd0, 64'hFFF, 3'd1, 32'hD13F_FC21, 32'h0});
        vecs.push_back('{2'd1, 5'd0, 5'd0, 5'd0, 64'h1001, 3'd0, 32'h0, 32'h0});
        vecs.push_back('{2'd1, 5'd0, 5'd0, 5'd0, 64'h100_0000, 3'd0, 32'h0, 32'h0});
        vecs.push_back('{2'd2, 5'd7, 5'd1, 5'd2, 64'h1234, 3'd1, 32'hEB02_003F, 32'h0});
        vecs.push_back('{2'd3, 5'd0, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFF8, 3'd1,
                         32'hB4FF_FFC0, 32'h0});
        vecs.push_back('{2'd3, 5'd0, 5'd0, 5'd0, 64'hF_FFFC, 3'd1, 32'hB47F_FFE0, 32'h0});
        vecs.push_back('{2'd3, 5'd0, 5'd0, 5'd0, 64'hFFFF_FFFF_FFF0_0000, 3'd1,
                         32'hB480_0000, 32'h0});
        vecs.push_back('{2'd3, 5'd0, 5'd0, 5'd0, 64'h10_0000, 3'd0, 32'h0, 32'h0});
        vecs.push_back('{2'd3, 5'd0, 5'd0, 5'd0, 64'h6, 3'd0, 32'h0, 32'h0});
        foreach (vecs[i]) begin
            v = vecs[i];
            run_cmd(v.op, v.rd, v.rn, v.rm, v.imm, 0);
            n_compared++;
            if (timed_out) begin
                n_mismatched++;
                $display("FAIL dir%0d_timeout: got timeout expected completion", i);
            end
            n_compared++;
            if (got_words.size() != int'(v.n)) begin
                n_mismatched++;
                $display("FAIL dir%0d_count: got %0d words expected %0d", i, got_words.size(), v.n);
            end
            n_compared++;
            if (err_cycles != ((v.n == 0) ? 1 : 0)) begin
                n_mismatched++;
                $display("FAIL dir%0d_err: got %0d err cycles expected %0d", i, err_cycles,
                         (v.n == 0) ? 1 : 0);
            end
            if (v.n != 0 && got_words.size() == int'(v.n)) begin
                n_compared++;
                if (got_words[0] !== v.w0 || got_last[0] !== (v.n == 1)) begin
                    n_mismatched++;
                    $display("FAIL dir%0d_word0: got %h last=%b expected %h last=%b", i,
                             got_words[0], got_last[0], v.w0, v.n == 1);
                end
                if (v.n == 2) begin
                    n_compared++;
                    if (got_words[1] !== v.w1 || got_last[1] !== 1'b1) begin
                        n_mismatched++;
                        $display("FAIL dir%0d_word1: got %h last=%b expected %h last=1", i,
                                 got_words[1], got_last[1], v.w1);
                    end
                end
                n_compared++;
                if (first_delay != 1) begin
                    n_mismatched++;
                    $display("FAIL dir%0d_latency: got %0d expected 1", i, first_delay);
                end
                n_compared++;
                if (hs_cyc[hs_cyc.size() - 1] - hs_cyc[0] != int'(v.n) - 1) begin
                    n_mismatched++;
                    $display("FAIL dir%0d_back_to_back: got span %0d expected %0d", i,
                             hs_cyc[hs_cyc.size() - 1] - hs_cyc[0], int'(v.n) - 1);
                end
            end
        end
    endtask

    task automatic test_stall;
        logic [31:0] exp4[4];
        exp4[0] = 32'hD29F_FFE0;
        exp4[1] = 32'hF2BF_FFE0;
        exp4[2] = 32'hF2DF_FFE0;
        exp4[3] = 32'hF2FF_FFE0;
        run_cmd(2'd0, 5'd0, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 3);
        n_compared++;
        if (timed_out || got_words.size() != 4) begin
            n_mismatched++;
            $display("FAIL stall_count: got %0d words timeout=%b expected 4", got_words.size(),
                     timed_out);
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_compared++;
                if (got_words[k] !== exp4[k] || got_last[k] !== (k == 3)) begin
                    n_mismatched++;
                    $display("FAIL stall_word%0d: got %h last=%b expected %h last=%b", k,
                             got_words[k], got_last[k], exp4[k], k == 3);
                end
            end
            n_compared++;
            if (hs_cyc[3] - hs_cyc[0] != 12) begin
                n_mismatched++;
                $display("FAIL stall_spacing: got %0d expected 12", hs_cyc[3] - hs_cyc[0]);
            end
        end
        n_compared++;
        if (!stable_ok) begin
            n_mismatched++;
            $display("FAIL stall_stable: got changing word expected held word");
        end
        n_compared++;
        if (!ready_ok) begin
            n_mismatched++;
            $display("FAIL stall_cmd_ready: got ready outside last handshake expected 0");
        end
    endtask

    task automatic test_back_to_back;
        // Two-word MOVI, with a CMP offered on the final word's handshake.
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_op     = 2'd0;
        cmd_rd     = 5'd1;
        cmd_rn     = 5'd0;
        cmd_rm     = 5'd0;
        cmd_imm    = 64'h0000_0000_0001_0002;
        inst_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        n_compared++;
        if (inst_valid !== 1'b1 || inst_data !== 32'hD280_0041 || inst_last !== 1'b0
            || cmd_ready !== 1'b0) begin
            n_mismatched++;
            $display("FAIL b2b_first: got v=%b %h last=%b rdy=%b expected v=1 d2800041 last=0 rdy=0",
                     inst_valid, inst_data, inst_last, cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        cmd_rd    = 5'd9;
        cmd_rn    = 5'd3;
        cmd_rm    = 5'd4;
        cmd_imm   = 64'h0;
        #1;
        n_compared++;
        if (inst_valid !== 1'b1 || inst_data !== 32'hF2A0_0021 || inst_last !== 1'b1
            || cmd_ready !== 1'b1) begin
            n_mismatched++;
            $display("FAIL b2b_last: got v=%b %h last=%b rdy=%b expected v=1 f2a00021 last=1 rdy=1",
                     inst_valid, inst_data, inst_last, cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        n_compared++;
        if (inst_valid !== 1'b1 || inst_data !== 32'hEB04_007F || inst_last !== 1'b1) begin
            n_mismatched++;
            $display("FAIL b2b_passthru: got v=%b %h last=%b expected v=1 eb04007f last=1",
                     inst_valid, inst_data, inst_last);
        end
        @(negedge clk);
        inst_ready = 1'b0;
        #1;
        n_compared++;
        if (inst_valid !== 1'b0) begin
            n_mismatched++;
            $display("FAIL b2b_drain: got inst_valid=%b expected 0", inst_valid);
        end
    endtask

    task automatic test_reset_mid;
        int extra;
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_op     = 2'd0;
        cmd_rd     = 5'd0;
        cmd_imm    = 64'hFFFF_FFFF_FFFF_FFFF;
        inst_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        #1;
        n_compared++;
        if (inst_data !== 32'hF2BF_FFE0) begin
            n_mismatched++;
            $display("FAIL midrst_word2: got %h expected f2bfffe0", inst_data);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_compared++;
        if (inst_valid !== 1'b0 || inst_data !== 32'h0) begin
            n_mismatched++;
            $display("FAIL midrst_flush: got v=%b %h expected v=0 00000000", inst_valid, inst_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (inst_valid) extra++;
        end
        inst_ready = 1'b0;
        n_compared++;
        if (extra != 0) begin
            n_mismatched++;
            $display("FAIL midrst_no_replay: got %0d valid cycles expected 0", extra);
        end
        run_cmd(2'd2, 5'd0, 5'd5, 5'd6, 64'h0, 0);
        n_compared++;
        if (timed_out || got_words.size() != 1 || got_words[0] !== 32'hEB06_00BF) begin
            n_mismatched++;
            $display("FAIL midrst_cmp: got %0d words first=%h expected 1 word eb0600bf",
                     got_words.size(), (got_words.size() > 0) ? got_words[0] : 32'h0);
        end
    endtask

    task automatic test_random;
        logic [1:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [63:0] imm;
        longint      v;
        int          stall;
        for (int t = 0; t < 60; t++) begin
            op  = 2'($urandom_range(0, 3));
            rd  = 5'($urandom);
            rn  = 5'($urandom);
            rm  = 5'($urandom);
            imm = '0;
            case ($urandom_range(0, 5))
                0: imm = {$urandom, $urandom};
                1: imm = 64'($urandom_range(0, 4095));
                2: imm = 64'($urandom_range(0, 4095)) << 12;
                3: for (int k = 0; k < 4; k++) begin
                    if ($urandom_range(0, 1) == 1) imm[k*16 +: 16] = 16'($urandom);
                end
                4: begin
                    v   = longint'($urandom_range(0, 524287)) - 262144;
                    imm = 64'(v * 4);
                    if ($urandom_range(0, 3) == 0) imm = imm + 64'd2;
                end
                default: imm = '0;
            endcase
            stall = $urandom_range(0, 2);
            model_cmd(op, rd, rn, rm, imm);
            run_cmd(op, rd, rn, rm, imm, stall);
            n_compared++;
            if (timed_out || got_words.size() != exp_words.size()) begin
                n_mismatched++;
                $display("FAIL rnd%0d_count: op=%0d imm=%h got %0d words expected %0d", t, op,
                         imm, got_words.size(), exp_words.size());
            end else begin
                foreach (exp_words[k]) begin
                    n_compared++;
                    if (got_words[k] !== exp_words[k]
                        || got_last[k] !== (k == exp_words.size() - 1)) begin
                        n_mismatched++;
                        $display("FAIL rnd%0d_word%0d: op=%0d imm=%h got %h last=%b expected %h",
                                 t, k, op, imm, got_words[k], got_last[k], exp_words[k]);
                    end
                end
            end
            n_compared++;
            if (err_cycles != (exp_err ? 1 : 0)) begin
                n_mismatched++;
                $display("FAIL rnd%0d_err: op=%0d imm=%h got %0d err cycles expected %0d", t, op,
                         imm, err_cycles, exp_err ? 1 : 0);
            end
            if (!exp_err) begin
                n_compared++;
                if (first_delay != 1 || !stable_ok || !ready_ok) begin
                    n_mismatched++;
                    $display("FAIL rnd%0d_handshake: got delay=%0d stable=%b ready=%b expected 1/1/1",
                             t, first_delay, stable_ok, ready_ok);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
